// File: rtl/cart_sdram_arbiter.sv
// Arbitrates one SDRAM port between ioctl loader byte writes and Z80 cart reads.
// CPU read latency is the mem_ack cycle + 1; ld_wait and cpu_wait_n stall the requesters.
// Optional one-entry read cache when CART_RD_CACHE_EN is defined.
module cart_sdram_arbiter #(
  parameter int ADDR_W        = 25,
  parameter int ACK_TIMEOUT   = 255,
  parameter int MAX_CPU_BURST = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_active,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_wait,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_wait_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              err_ovf,
  output logic              err_timeout
);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int BW = $clog2(MAX_CPU_BURST + 1);

  typedef enum logic [1:0] {IDLE, LD_ACC, CPU_ACC, DONE} state_t;

  state_t            state, state_nxt;
  logic              cpu_rd_q;
  logic              ld_pend, cpu_pend, cpu_queued;
  logic [ADDR_W-1:0] ld_addr_q, cpu_addr_q;
  logic [7:0]        ld_data_q;
  logic [TW-1:0]     tmr;
  logic [BW-1:0]     cpu_burst;

  logic start, hit, cpu_start_acc, ld_take;
  logic in_acc, acc_end, tmo, ld_end, cpu_end, cpu_ok;
  logic grant_ld, grant_cpu, burst_full;
  logic [7:0] hit_data;

  assign start         = cpu_rd & ~cpu_rd_q;
  assign cpu_start_acc = start & ~hit;
  assign ld_take       = ld_wr & ~ld_pend;

  assign in_acc     = (state == LD_ACC) || (state == CPU_ACC);
  assign tmo        = in_acc & ~mem_ack & (tmr == TW'(ACK_TIMEOUT - 1));
  assign acc_end    = in_acc & (mem_ack | tmo);
  assign ld_end     = (state == LD_ACC) & acc_end;
  assign cpu_end    = (state == CPU_ACC) & acc_end;
  assign cpu_ok     = (state == CPU_ACC) & mem_ack;
  assign burst_full = (cpu_burst == BW'(MAX_CPU_BURST));
  assign grant_ld   = (state == IDLE) && (state_nxt == LD_ACC);
  assign grant_cpu  = (state == IDLE) && (state_nxt == CPU_ACC);

  assign ld_wait    = ld_pend;
  assign cpu_wait_n = ~(cpu_start_acc | cpu_pend);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Loader wins when downloading, when it is the only requester, or when the CPU burst is used up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ld_pend && (!cpu_pend || ld_active || burst_full)) state_nxt = LD_ACC;
        else if (cpu_pend)                                     state_nxt = CPU_ACC;
      end
      LD_ACC, CPU_ACC: if (acc_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req = in_acc;
    mem_we  = (state == LD_ACC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rd_q    <= 1'b0;
      ld_pend     <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      err_ovf     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cpu_rd_q    <= cpu_rd;
      err_ovf     <= err_ovf | (ld_wr & ld_pend);
      err_timeout <= err_timeout | tmo;
      if (ld_take) begin
        ld_pend   <= 1'b1;
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end else if (ld_end) begin
        ld_pend   <= 1'b0;
      end
    end
  end

  // A new read arriving while an older one is on the bus must survive that older completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_pend   <= 1'b0;
      cpu_queued <= 1'b0;
      cpu_addr_q <= '0;
      cpu_data   <= 8'hFF;
    end else begin
      if ((state == CPU_ACC) && !cpu_end) cpu_queued <= cpu_queued | cpu_start_acc;
      else                                cpu_queued <= 1'b0;
      if (cpu_start_acc) begin
        cpu_pend   <= 1'b1;
        cpu_addr_q <= cpu_addr;
      end else if (cpu_end && !cpu_queued) begin
        cpu_pend   <= 1'b0;
      end
      if (hit)          cpu_data <= hit_data;
      else if (cpu_end) cpu_data <= cpu_ok ? mem_rdata : 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      tmr       <= '0;
      cpu_burst <= '0;
    end else begin
      tmr <= in_acc ? tmr + TW'(1) : '0;
      if (grant_ld) begin
        mem_addr  <= ld_addr_q;
        mem_wdata <= ld_data_q;
        cpu_burst <= '0;
      end else if (grant_cpu) begin
        mem_addr  <= cpu_addr_q;
        if (ld_pend && !burst_full) cpu_burst <= cpu_burst + BW'(1);
      end
    end
  end

`ifdef CART_RD_CACHE_EN
  logic              cache_vld, ld_active_q;
  logic [ADDR_W-1:0] cache_addr;
  logic [7:0]        cache_data;

  assign hit      = start & cache_vld & (cpu_addr == cache_addr);
  assign hit_data = cache_data;

  // Loader data captured this edge is newer than anything read back from SDRAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_vld   <= 1'b0;
      ld_active_q <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
    end else begin
      ld_active_q <= ld_active;
      if (ld_active && !ld_active_q) begin
        cache_vld  <= 1'b0;
      end else if (cpu_ok) begin
        cache_vld  <= 1'b1;
        cache_addr <= mem_addr;
        cache_data <= (ld_take && (ld_addr == mem_addr)) ? ld_data : mem_rdata;
      end else if (ld_take && cache_vld && (ld_addr == cache_addr)) begin
        cache_data <= ld_data;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 8'hFF;
`endif

endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Scoreboard bench for cart_sdram_arbiter: stimulus queues expected SDRAM accesses and CPU
// read results, a monitor compares them as the DUT presents mem_req rises and cpu_wait_n releases.
module tb_cart_sdram_arbiter;
  localparam int AW = 25;

  logic          clk;
  logic          reset_n;
  logic          ld_active, ld_wr, ld_wait;
  logic [AW-1:0] ld_addr, cpu_addr, mem_addr;
  logic [7:0]    ld_data, cpu_data, mem_wdata, mem_rdata;
  logic          cpu_rd, cpu_wait_n, mem_req, mem_we, mem_ack;
  logic          err_ovf, err_timeout;
  logic          resp_ack, spur_ack;

  assign mem_ack = resp_ack | spur_ack;

  cart_sdram_arbiter #(.ADDR_W(AW), .ACK_TIMEOUT(255), .MAX_CPU_BURST(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_active(ld_active), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_wait(ld_wait),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wait_n(cpu_wait_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err_ovf(err_ovf), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } mem_txn_t;

  mem_txn_t   exp_mem[$];
  logic [7:0] exp_cpu[$];
  int checks = 0;
  int errors = 0;
  int ack_delay = 4;
  bit no_ack = 0;

  function automatic mem_txn_t mk(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    mem_txn_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wn(input string name);
    int n = 0;
    while (!cpu_wait_n && n < 2000) begin cyc(1); n++; end
    check(name, cpu_wait_n, 1);
  endtask

  task automatic wait_ld(input string name);
    int n = 0;
    while (ld_wait && n < 2000) begin cyc(1); n++; end
    check(name, ld_wait, 0);
  endtask

  task automatic wait_mem_rise(input string name);
    int n = 0;
    logic last;
    last = mem_req;
    cyc(1);
    while (!(mem_req && !last) && n < 2000) begin last = mem_req; cyc(1); n++; end
    check(name, mem_req, 1);
  endtask

  // SDRAM model: ack in the ack_delay-th cycle of mem_req high
  initial begin
    int rcnt;
    rcnt = 0;
    resp_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        rcnt++;
        resp_ack = !no_ack && (rcnt == ack_delay);
      end else begin
        rcnt = 0;
        resp_ack = 1'b0;
      end
    end
  end

  initial begin
    mem_txn_t t;
    logic req_q, wn_q;
    req_q = 1'b0;
    wn_q  = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_req && !req_q) begin
          if (exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: actual addr=%0h we=%0b, required none", mem_addr, mem_we);
          end else begin
            t = exp_mem.pop_front();
            check("mem_we", mem_we, t.we);
            check("mem_addr", mem_addr, t.addr);
            if (t.we) check("mem_wdata", mem_wdata, t.data);
          end
        end
        if (cpu_wait_n && !wn_q) begin
          if (exp_cpu.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cpu_release: actual data=%0h, required none", cpu_data);
          end else begin
            check("cpu_data", cpu_data, exp_cpu.pop_front());
          end
        end
      end
      req_q = mem_req;
      wn_q  = cpu_wait_n;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ld_active = 0; ld_wr = 0; ld_addr = '0; ld_data = '0;
    cpu_rd = 0; cpu_addr = '0; mem_rdata = '0; spur_ack = 0;
    reset_n = 0;
    cyc(3);
    check("rst_cpu_wait_n", cpu_wait_n, 1);
    check("rst_cpu_data", cpu_data, 8'hFF);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_ld_wait", ld_wait, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_timeout", err_timeout, 0);
    reset_n = 1;
    cyc(2);

    // loader write, ack in 4th request cycle: ld_wait high 5 cycles
    ld_active = 1; ack_delay = 4;
    exp_mem.push_back(mk(1'b1, 'h10, 8'h5A));
    ld_addr = 'h10; ld_data = 8'h5A; ld_wr = 1;
    #1 check("ld_wait_same_cycle", ld_wait, 0);
    cyc(1); ld_wr = 0;
    n = 0;
    while (ld_wait && n < 100) begin n++; cyc(1); end
    check("ld_wait_cycles", n, 5);
    cyc(2);

    // CPU read 0x04000, ack in 6th cycle: WAIT low same cycle, 8 low cycles total
    ack_delay = 6; mem_rdata = 8'hC3; cpu_addr = 'h4000;
    exp_mem.push_back(mk(1'b0, 'h4000, 8'h00));
    exp_cpu.push_back(8'hC3);
    cpu_rd = 1;
    #1 check("wait_same_cycle", cpu_wait_n, 0);
    n = 0;
    while (!cpu_wait_n && n < 100) begin n++; cyc(1); end
    check("cpu_read_latency", n, 8);
    cpu_rd = 0;
    cyc(2);

    // back-to-back CPU reads against a pending loader write: CPU, CPU, LD, CPU
    ld_active = 0; ack_delay = 3; mem_rdata = 8'h3C;
    exp_mem.push_back(mk(1'b0, 'h100, 8'h00));
    exp_mem.push_back(mk(1'b0, 'h101, 8'h00));
    exp_mem.push_back(mk(1'b1, 'h20, 8'hA5));
    exp_mem.push_back(mk(1'b0, 'h102, 8'h00));
    exp_cpu.push_back(8'h3C);
    ld_addr = 'h20; ld_data = 8'hA5; ld_wr = 1; cpu_addr = 'h100; cpu_rd = 1;
    cyc(1); ld_wr = 0;
    for (int k = 1; k <= 2; k++) begin
      wait_mem_rise("burst_req_rise");
      cpu_rd = 0;
      cyc(1);
      cpu_addr = AW'('h100 + k);
      cpu_rd = 1;
    end
    wait_wn("burst_wait_release");
    cpu_rd = 0;
    wait_ld("burst_ld_release");
    cyc(2);

    // no ack: abort after exactly 255 request cycles, data FF
    check("err_timeout_pre", err_timeout, 0);
    no_ack = 1; cpu_addr = 'h123;
    exp_mem.push_back(mk(1'b0, 'h123, 8'h00));
    exp_cpu.push_back(8'hFF);
    cpu_rd = 1;
    wait_mem_rise("tmo_req_rise");
    n = 1;
    while (mem_req && n < 1000) begin cyc(1); if (mem_req) n++; end
    check("timeout_req_cycles", n, 255);
    check("err_timeout", err_timeout, 1);
    wait_wn("tmo_wait_release");
    cpu_rd = 0; no_ack = 0;
    cyc(2);

    // next request after abort is serviced
    ld_active = 1; ack_delay = 2;
    exp_mem.push_back(mk(1'b1, 'h1FFFFFF, 8'h81));
    ld_addr = 'h1FFFFFF; ld_data = 8'h81; ld_wr = 1;
    cyc(1); ld_wr = 0;
    wait_ld("post_tmo_ld_release");
    cyc(2);

    // second strobe while ld_wait is dropped and flagged
    ack_delay = 5;
    exp_mem.push_back(mk(1'b1, 'h30, 8'h77));
    ld_addr = 'h30; ld_data = 8'h77; ld_wr = 1;
    cyc(1);
    check("err_ovf_pre", err_ovf, 0);
    ld_addr = 'h31; ld_data = 8'h88;
    cyc(1); ld_wr = 0;
    check("err_ovf", err_ovf, 1);
    wait_ld("ovf_ld_release");
    cyc(3);

    // stray ack while idle is ignored
    mem_rdata = 8'h99; spur_ack = 1;
    cyc(1); spur_ack = 0;
    cyc(2);
    check("spur_cpu_data", cpu_data, 8'hFF);
    check("spur_mem_req", mem_req, 0);
    check("spur_cpu_wait_n", cpu_wait_n, 1);

`ifdef CART_RD_CACHE_EN
    ld_active = 0; cyc(1); ld_active = 1; cyc(2);
    ack_delay = 3; mem_rdata = 8'hC3; cpu_addr = 'h4000;
    exp_mem.push_back(mk(1'b0, 'h4000, 8'h00));
    exp_cpu.push_back(8'hC3);
    cpu_rd = 1;
    cyc(1);
    wait_wn("fill_wait_release");
    cpu_rd = 0;
    cyc(2);
    mem_rdata = 8'h00; cpu_rd = 1;
    #1 check("hit_wait_same_cycle", cpu_wait_n, 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin if (!cpu_wait_n || mem_req) n++; cyc(1); end
    check("hit_no_stall", n, 0);
    check("hit_cpu_data", cpu_data, 8'hC3);
    cpu_rd = 0;
    cyc(2);
    exp_mem.push_back(mk(1'b1, 'h4000, 8'h11));
    ld_addr = 'h4000; ld_data = 8'h11; ld_wr = 1;
    cyc(1); ld_wr = 0;
    wait_ld("cache_ld_release");
    cyc(2);
    cpu_rd = 1;
    cyc(1);
    check("hit_updated_data", cpu_data, 8'h11);
    check("hit_updated_wait_n", cpu_wait_n, 1);
    cpu_rd = 0;
    cyc(2);
`endif

    cyc(10);
    check("exp_mem_left", exp_mem.size(), 0);
    check("exp_cpu_left", exp_cpu.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
